// File: rtl/pi_cmd_pkg.sv
// Purpose: shared frame layout, FSM encodings and checksum helper for the Pi command receiver.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pi_cmd_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int BIT_CNT_W   = 5;
  localparam int BIT_CNT_MAX = 17;   // anything past 16 is an overrun; no need to count further

  // Field positions inside the 16-bit frame (bit 15 is first on the wire)
  localparam int SUNRISE_BIT = 0;
  localparam int SUNSET_BIT  = 1;
  localparam int BRIGHT_LSB  = 2;
  localparam int BRIGHT_MSB  = 6;
  localparam int RSVD_LSB    = 7;
  localparam int RSVD_MSB    = 8;
  localparam int SPEED_LSB   = 9;
  localparam int SPEED_MSB   = 10;
  localparam int PRECIP_BIT  = 11;
  localparam int CHECK_LSB   = 12;
  localparam int CHECK_MSB   = 15;

  // Receiver FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Check nibble: XOR of the three low nibbles, reserved bits included.
  function automatic logic [3:0] cmd_check(input logic [FRAME_BITS-1:0] w);
    return w[3:0] ^ w[7:4] ^ w[11:8];
  endfunction

endpackage

// File: rtl/pi_cmd_rx_sync_edge.sv
// Purpose: multi-flop synchroniser for one asynchronous pin, with rise/fall pulses on the synced copy.
// Latency: a pin change sampled on edge 1 appears on dout/rise/fall after edge STAGES.
// Backpressure: none; pulses are single-cycle and unconditional.
//
// Ports: clk, reset (sync, active-high), din (async pin), dout (synchronised level),
//        rise / fall (one-cycle pulses on dout transitions). STAGES must be >= 2.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/pi_cmd_rx.sv
// Purpose: SPI-slave receiver for 16-bit Pi scene frames; validates and commits scene fields.
// Latency: commit/reject pulse on the SYNC_STAGES+2 clk edge after pi_ce_n is first sampled high.
// Backpressure: none; the Pi paces frames, a ce_n fall during CHECK is held until IDLE.
//
// Ports: clk, reset (sync, active-high); pi_sck/pi_mosi/pi_ce_n (async SPI mode 0 inputs);
//        pi_miso (registered echo of last committed word); scene fields sunrise, sunset,
//        brightness, speed, precip; cmd_valid / frame_err pulses; err_count (saturating).
module pi_cmd_rx
  import pi_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pi_sck,
  input  logic                 pi_mosi,
  input  logic                 pi_ce_n,
  output logic                 pi_miso,
  output logic                 sunrise,
  output logic                 sunset,
  output logic [4:0]           brightness,
  output logic [1:0]           speed,
  output logic                 precip,
  output logic                 cmd_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic sck_rise, sck_fall, sck_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic ce_rise, ce_fall, ce_lvl_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .reset (reset),
    .din   (pi_sck),
    .dout  (sck_lvl_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (pi_mosi),
    .dout  (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // ce_n resets to "asserted" so a frame already in flight when reset drops
  // produces no fall edge; it is ignored until the next genuine ce_n fall.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ce (
    .clk   (clk),
    .reset (reset),
    .din   (pi_ce_n),
    .dout  (ce_lvl_unused),
    .rise  (ce_rise),
    .fall  (ce_fall)
  );

  logic [1:0]            state_q,     state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q,     shift_d;
  logic [FRAME_BITS-1:0] miso_sr_q,   miso_sr_d;
  logic [FRAME_BITS-1:0] word_q,      word_d;     // last committed frame
  logic                  pi_miso_q,   pi_miso_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  pend_q,      pend_d;     // ce_n fall seen during CHECK
  logic [ERR_CNT_W-1:0]  err_cnt_q,   err_cnt_d;
  logic                  frame_ok;

  assign frame_ok = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) &&
                    (shift_q[CHECK_MSB:CHECK_LSB] == cmd_check(shift_q)) &&
                    !(shift_q[SUNRISE_BIT] && shift_q[SUNSET_BIT]);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    miso_sr_d   = miso_sr_q;
    word_d      = word_q;
    pi_miso_d   = pi_miso_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    pend_d      = pend_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (ce_fall || pend_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shift_d   = '0;
          pend_d    = 1'b0;
          // MSB must be on the wire before the first sck rise (mode 0)
          miso_sr_d = word_q;
          pi_miso_d = word_q[FRAME_BITS-1];
        end else begin
          pi_miso_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        // ce_n rise takes priority; a coincident sck rise is dropped
        if (ce_rise) begin
          state_d   = ST_CHECK;
          pi_miso_d = 1'b0;
        end else begin
          if (sck_rise) begin
            shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt_q != BIT_CNT_W'(BIT_CNT_MAX)) begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
          if (sck_fall) begin
            miso_sr_d = {miso_sr_q[FRAME_BITS-2:0], 1'b0};
            pi_miso_d = miso_sr_q[FRAME_BITS-2];
          end
        end
      end

      ST_CHECK: begin
        state_d   = ST_IDLE;
        pi_miso_d = 1'b0;
        if (ce_fall) begin
          pend_d = 1'b1;
        end
        if (frame_ok) begin
          word_d      = shift_q;
          cmd_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pi_miso_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      miso_sr_q   <= '0;
      word_q      <= '0;
      pi_miso_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      miso_sr_q   <= miso_sr_d;
      word_q      <= word_d;
      pi_miso_q   <= pi_miso_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      pend_q      <= pend_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign pi_miso    = pi_miso_q;
  assign sunrise    = word_q[SUNRISE_BIT];
  assign sunset     = word_q[SUNSET_BIT];
  assign brightness = word_q[BRIGHT_MSB:BRIGHT_LSB];
  assign speed      = word_q[SPEED_MSB:SPEED_LSB];
  assign precip     = word_q[PRECIP_BIT];
  assign cmd_valid  = cmd_valid_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: doc/pi_cmd_rx.md
# pi_cmd_rx

Receives 16-bit scene command frames from the Raspberry Pi over SPI (Pi is master, FPGA is slave) and presents validated, registered scene fields to the lantern and rain generators. It replaces the hard-wired command word that currently drives sunrise, sunset, brightness, speed and precipitation. All Pi pins are asynchronous to `clk` and are synchronised inside the block. Command outputs change only on a clean, checksum-valid frame.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on `pi_sck`, `pi_mosi` and `pi_ce_n`.
- `ERR_CNT_W`, 8: width of the saturating error counter.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `pi_sck` in 1: SPI clock from the Pi. SPI mode 0. High and low phases must each be ≥ 4 `clk` periods.
- `pi_mosi` in 1: serial data, MSB first, sampled on rising `pi_sck`.
- `pi_ce_n` in 1: active-low frame enable.
- `pi_miso` out 1: status echo, changes on falling `pi_sck`.
- `sunrise`, `sunset` out 1 each: scene flags.
- `brightness` out 5: APA102 global brightness.
- `speed` out 2: rain speed select.
- `precip` out 1: 1 = rain, 0 = snow.
- `cmd_valid` out 1: one-cycle pulse when new fields are committed.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.
- `err_count` out `ERR_CNT_W`: rejected-frame count, saturating.

## Operation
- Frame layout, bit 15 first on the wire:
  - [0] sunrise
  - [1] sunset
  - [6:2] brightness
  - [8:7] reserved
  - [10:9] speed
  - [11] precip
  - [15:12] check = [3:0] ^ [7:4] ^ [11:8]
- All three Pi inputs are synchronised; edges are detected on the synchronised copies.
- FSM states and transitions:
  - IDLE: on `ce_n` fall → SHIFT; clear bit count and shift register; load the MISO shift register with the last committed word.
  - SHIFT: on each `sck` rise, shift in `mosi` and increment the bit count (5-bit, saturates at 17). On `sck` fall, shift MISO. On `ce_n` rise → CHECK.
  - CHECK, one cycle, then → IDLE. The frame is accepted only if bit count == 16, the check nibble matches, and sunrise & sunset is not 1.
    - Accept: commit fields, pulse `cmd_valid`.
    - Reject: hold fields, pulse `frame_err`, increment `err_count` (saturates at all-ones).
- Simultaneous `ce_n` rise and `sck` rise in the same synchronised cycle: `ce_n` wins and the `sck` edge is discarded.
- Fewer than 16 bits (short frame) or 17 or more bits (overrun): reject.
- Reset, including mid-frame:
  - FSM → IDLE; partial frame discarded.
  - All outputs and `err_count` = 0; last committed word = 0.
  - A frame already in progress when reset deasserts is ignored until the next `ce_n` fall.
- Reserved bits are ignored but are included in the checksum.

## Timing
- Synchroniser plus edge detect: an input change is seen as an edge `SYNC_STAGES` `clk` edges after it is sampled.
- Commit latency: fields, `cmd_valid` and `frame_err` update on the `SYNC_STAGES`+2 `clk` edge after `pi_ce_n` is first sampled high (4 edges at default).
- `cmd_valid` and `frame_err` are exactly one cycle wide and mutually exclusive.
- `pi_miso` is registered. Its value is undefined when `pi_ce_n` is high; the block drives 0 there.
- Back-to-back frames need ≥ 1 `clk` of `ce_n` high after CHECK; a `ce_n` fall during CHECK is held and acted on in IDLE.

## Structure
- Shared package `pi_cmd_pkg` holds:
  - Field bit positions and `FRAME_BITS` = 16.
  - FSM enum (IDLE, SHIFT, CHECK).
  - `cmd_check()` checksum function.
- Sub-module `sync_edge`: `SYNC_STAGES`-flop synchroniser with rise and fall pulse outputs. Instantiated three times.
- Top level: FSM, shift registers, commit register, error counter.

## Test plan
- Frame 0x8C62 (sunset, brightness 11000, speed 10, rain) → `cmd_valid` pulse; sunset=1, brightness=0x18, speed=2, precip=1; `err_count`=0.
- Frame 0x0C62 (bad check) → `frame_err` pulse; outputs hold their previous values; `err_count`=1.
- Frame 0x9C63 (sunrise & sunset both set, check valid) → rejected; `err_count` increments.
- 15-bit frame, then 17-bit frame → two rejects; next 0x8C62 accepted.
- Reset asserted after 8 bits of a frame → all outputs 0; remainder of that frame ignored; next valid frame commits.
- Frame 0x8C62 committed, then any next frame → `pi_miso` streams 0x8C62 MSB first; 300 bad frames → `err_count` saturates at 255.
